// File: rtl/dmux_stream_router.sv
// Buffered 1-to-N stream demultiplexer: each accepted word goes to one channel FIFO
// (or all of them in broadcast); out-of-range unicast selects are dropped and counted.
module dmux_stream_router #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DEPTH    = 4,
   localparam int unsigned SELW    = $clog2(CHANNELS)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [WIDTH-1:0]            in_data_i,
   input  logic [SELW-1:0]             in_sel_i,
   input  logic                        in_bcast_i,
   output logic [CHANNELS-1:0]         out_valid_o,
   input  logic [CHANNELS-1:0]         out_ready_i,
   output logic [CHANNELS*WIDTH-1:0]   out_data_o,
   output logic [7:0]                  drop_count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   typedef logic [PW:0] ptr_t;

   logic [WIDTH-1:0]    mem_q [CHANNELS][DEPTH];
   ptr_t                wr_ptr_q [CHANNELS];
   ptr_t                wr_ptr_d [CHANNELS];
   ptr_t                rd_ptr_q [CHANNELS];
   ptr_t                rd_ptr_d [CHANNELS];
   logic [7:0]          drop_q, drop_d;
   logic [CHANNELS-1:0] full, empty, sel_hit, push, pop;
   logic                sel_ok, accept, drop;

   always_comb begin
      full    = '0;
      empty   = '0;
      sel_hit = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         empty[k]   = (wr_ptr_q[k] == rd_ptr_q[k]);
         full[k]    = (wr_ptr_q[k][PW] != rd_ptr_q[k][PW]) &&
                      (wr_ptr_q[k][PW-1:0] == rd_ptr_q[k][PW-1:0]);
         sel_hit[k] = (in_sel_i == SELW'(k));
      end
   end

   // An unmatched select can only mean an out-of-range index, which is always accepted.
   assign sel_ok     = |sel_hit;
   assign in_ready_o = in_bcast_i ? ~|full : (~sel_ok || |(sel_hit & ~full));
   assign accept     = in_valid_i && in_ready_o && !rst_i;
   assign drop       = accept && !in_bcast_i && !sel_ok;

   always_comb begin
      push = '0;
      pop  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         push[k]     = accept && (in_bcast_i || sel_hit[k]);
         pop[k]      = !empty[k] && out_ready_i[k] && !rst_i;
         wr_ptr_d[k] = wr_ptr_q[k] + ptr_t'(push[k]);
         rd_ptr_d[k] = rd_ptr_q[k] + ptr_t'(pop[k]);
      end
      drop_d = drop_q;
      if (drop && drop_q != 8'hFF) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < CHANNELS; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
         end
         drop_q <= '0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
         end
         drop_q <= drop_d;
      end
   end

   // Storage is deliberately left out of reset; empty FIFOs mask it on the output.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
         if (push[k]) begin
            mem_q[k][wr_ptr_q[k][PW-1:0]] <= in_data_i;
         end
      end
   end

   always_comb begin
      out_data_o = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (!empty[k]) begin
            out_data_o[k*WIDTH +: WIDTH] = mem_q[k][rd_ptr_q[k][PW-1:0]];
         end
      end
   end

   assign out_valid_o  = ~empty;
   assign drop_count_o = drop_q;

endmodule

// File: tb/tb_dmux_stream_router.sv
// Bench for dmux_stream_router: directed steps plus random traffic checked against
// a queue-based reference model; a 3-channel instance covers out-of-range drops.
module tb_dmux_stream_router;

   localparam int unsigned W = 8;
   localparam int unsigned C = 4;
   localparam int unsigned D = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, in_bcast, in_ready;
   logic [W-1:0]   in_data;
   logic [1:0]     in_sel;
   logic [C-1:0]   out_valid, out_ready;
   logic [C*W-1:0] out_data;
   logic [7:0]     drop_count;

   logic           v3, b3, r3;
   logic [W-1:0]   d3;
   logic [1:0]     s3;
   logic [2:0]     ov3, or3;
   logic [3*W-1:0] od3;
   logic [7:0]     dc3;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] q [C][$];
   int           mdrop;

   always #5 clk = ~clk;

   dmux_stream_router #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .in_sel_i     (in_sel),
      .in_bcast_i   (in_bcast),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .drop_count_o (drop_count)
   );

   dmux_stream_router #(.WIDTH(W), .CHANNELS(3), .DEPTH(D)) u_dut3 (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (v3),
      .in_ready_o   (r3),
      .in_data_i    (d3),
      .in_sel_i     (s3),
      .in_bcast_i   (b3),
      .out_valid_o  (ov3),
      .out_ready_i  (or3),
      .out_data_o   (od3),
      .drop_count_o (dc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare against the model before the edge, then advance the model by one edge.
   task automatic tick();
      logic [C-1:0]   ev;
      logic [C*W-1:0] ed;
      logic           er;
      int             sz [C];
      @(negedge clk);
      ed = '0;
      for (int k = 0; k < C; k++) begin
         sz[k] = q[k].size();
         ev[k] = (sz[k] != 0);
         if (ev[k]) ed[k*W +: W] = q[k][0];
      end
      if (in_bcast) begin
         er = 1'b1;
         for (int k = 0; k < C; k++) if (sz[k] == D) er = 1'b0;
      end else if (int'(in_sel) < C) begin
         er = (sz[in_sel] != D);
      end else begin
         er = 1'b1;
      end
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out_data", out_data, ed);
      check("drop_count", 32'(drop_count), mdrop);
      if (rst) begin
         for (int k = 0; k < C; k++) q[k].delete();
         mdrop = 0;
      end else begin
         for (int k = 0; k < C; k++) if (out_ready[k] && sz[k] != 0) void'(q[k].pop_front());
         if (in_valid && er) begin
            if (in_bcast) begin
               for (int k = 0; k < C; k++) q[k].push_back(in_data);
            end else if (int'(in_sel) < C) begin
               q[in_sel].push_back(in_data);
            end else if (mdrop < 255) begin
               mdrop++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd0; in_bcast = 1'b0;
      out_ready = '0;
      v3 = 1'b0; b3 = 1'b0; s3 = 2'd0; d3 = '0; or3 = '0;
      for (int k = 0; k < C; k++) q[k].delete();
      mdrop = 0;

      // Reset held for two edges with a word presented
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", out_data, 32'h0);
      check("rst_drop", 32'(drop_count), 32'h0);
      tick();
      rst = 1'b0; in_valid = 1'b0;
      tick();
      tick();
      check("rst_no_word", 32'(out_valid), 32'h0);

      // Out-of-range drops on the 3-channel instance
      check("d3_reset", 32'(dc3), 32'd0);
      v3 = 1'b1; s3 = 2'd3; d3 = 8'h5A;
      #1;
      check("d3_ready", 32'(r3), 32'd1);
      @(posedge clk); #1;
      check("d3_count1", 32'(dc3), 32'd1);
      check("d3_no_valid", 32'(ov3), 32'd0);
      repeat (299) @(posedge clk);
      #1;
      check("d3_saturate", 32'(dc3), 32'd255);
      s3 = 2'd1; d3 = 8'h42;
      @(posedge clk); #1;
      v3 = 1'b0;
      check("d3_uni_valid", 32'(ov3), 32'b010);
      check("d3_uni_data", 32'(od3), 32'h004200);
      check("d3_count_hold", 32'(dc3), 32'd255);

      // Unicast with a stalled consumer
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("uni_valid", 32'(out_valid), 32'b0100);
         check("uni_slice", 32'(out_data[2*W +: W]), 32'hA5);
         tick();
      end
      out_ready = 4'b0100;
      tick();
      out_ready = '0;
      check("uni_popped", 32'(out_valid), 32'h0);

      // Fill channel 1 and test back-pressure
      in_valid = 1'b1; in_sel = 2'd1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'(8'h10 + i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("full_ready_ch1", 32'(in_ready), 32'd0);
      in_sel = 2'd0;
      #1;
      check("full_ready_ch0", 32'(in_ready), 32'd1);
      check("full_head", 32'(out_data[W +: W]), 32'h10);
      in_sel = 2'd1; in_valid = 1'b1; in_data = 8'h99; out_ready = 4'b0010;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         check("drain_order", 32'(out_data[W +: W]), 32'(8'h10 + i));
         tick();
      end
      check("drain_empty", 32'(out_valid), 32'h0);
      out_ready = '0;

      // Broadcast, then broadcast blocked by a full channel 3
      in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'h3C;
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
      check("bc_valid", 32'(out_valid), 32'hF);
      check("bc_data", out_data, 32'h3C3C3C3C);
      in_valid = 1'b1; in_sel = 2'd3;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'hE0 + i);
         tick();
      end
      in_bcast = 1'b1; in_data = 8'h55;
      #1;
      check("bc_blocked", 32'(in_ready), 32'd0);
      tick();
      tick();
      check("bc_no_write", 32'(out_valid), 32'hF);
      check("bc_ch0_head", 32'(out_data[7:0]), 32'h3C);
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'hF;
      repeat (5) tick();
      out_ready = '0;

      // Reset mid-operation discards buffered words
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01;
      tick();
      in_data = 8'h02;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      in_valid = 1'b1; in_data = 8'h77;
      tick();
      in_valid = 1'b0;
      check("mid_rst_head", 32'(out_data[7:0]), 32'h77);
      check("mid_rst_ovalid", 32'(out_valid), 32'b0001);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(1));
         in_data   = 8'($urandom);
         in_sel    = 2'($urandom_range(3));
         in_bcast  = ($urandom_range(7) == 0);
         out_ready = 4'($urandom);
         rst       = ($urandom_range(99) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
